program_field_counter: RTL and testbench
========================================

PROGRAM_FIELD_COUNTER -- requirements
Module: program_field_counter

Interface
REQ-001 Parameter MAX, default 59, largest legal field value; SHALL be 1..99.
REQ-002 Parameter WIDTH, default 7, value bus width; SHALL satisfy 2**WIDTH > MAX.
REQ-003 Parameter WRAP, default 1: 1 = modular wrap with carry, 0 = saturate without carry.
REQ-004 Parameter HOLD_CYCLES, default 500, continuous-hold cycles before auto-repeat starts; SHALL be >= 1.
REQ-005 Parameter REPEAT_CYCLES, default 100, cycles between auto-repeat steps; SHALL be >= 1.
REQ-006 Parameter INIT, default 0, value after reset.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 en  in  1  program mode active; steps are accepted only while high.
REQ-011 load  in  1  load start_value this cycle.
REQ-012 start_value  in  WIDTH  value to load.
REQ-013 add  in  1  increment button level, may be held.
REQ-014 subtract  in  1  decrement button level, may be held.
REQ-015 value  out  WIDTH  registered field value.
REQ-016 tens  out  4  value / 10.
REQ-017 units  out  4  value % 10.
REQ-018 carry_pos  out  1  one-cycle pulse on upward wrap.
REQ-019 carry_neg  out  1  one-cycle pulse on downward wrap.

Function
REQ-020 Step request: one rising edge of add or subtract (registered previous level low, current level high), with en high, SHALL step value on that same clock edge.
REQ-021 A single step request SHALL update value exactly once, and value SHALL be visible on the following cycle.
REQ-022 Hold FSM states: IDLE, HOLD and REPEAT.
REQ-023 IDLE -> HOLD on a step request; the hold counter clears.
REQ-024 HOLD: while the same button stays high, after HOLD_CYCLES cycles SHALL issue one step and go to REPEAT.
REQ-025 REPEAT: SHALL issue one step every REPEAT_CYCLES cycles while the button stays high.
REQ-026 Button release, en low, load, or both buttons high SHALL return the FSM to IDLE with no step in that cycle.
REQ-027 add and subtract both high SHALL produce no step; value SHALL hold.
REQ-028 Increment at value == MAX: with WRAP=1, value SHALL become 0 and carry_pos SHALL pulse; with WRAP=0, value SHALL stay at MAX and there is no pulse.
REQ-029 Decrement at value == 0: with WRAP=1, value SHALL become MAX and carry_neg SHALL pulse; with WRAP=0, value SHALL stay at 0 and there is no pulse.
REQ-030 Any other step SHALL change value by +/-1 without a carry.
REQ-031 Carry pulses SHALL be registered, high exactly one cycle, and coincide with the value update.
REQ-032 load SHALL have priority over steps and SHALL work regardless of en.
REQ-033 On load, value SHALL become min(start_value, MAX), and no carry SHALL be generated.
REQ-034 en low SHALL freeze value, clear the FSM and block steps.
REQ-035 tens and units SHALL be combinational from value and always consistent with it.

Reset
REQ-036 When rst is high at a clock edge, value SHALL become INIT, carry_pos and carry_neg SHALL be 0, the FSM SHALL go to IDLE, and the counters and edge-detect registers SHALL clear.
REQ-037 Reset SHALL override load and steps.
REQ-038 A button still held when reset releases SHALL NOT step until it is released and pressed again.

Structure
REQ-039 Shared package alarm_pkg SHALL hold the FSM state encoding (IDLE/HOLD/REPEAT) and the default MAX constants (HOUR_MAX=23, MIN_MAX=59).
REQ-040 The button edge-detect logic and the hold/repeat FSM SHALL live in sub-module hold_repeat, which outputs a single-cycle step_up and step_dn.
REQ-041 program_field_counter SHALL hold only the value register, the wrap/saturate arithmetic and the BCD split.

Verification (MAX=59, WRAP=1, HOLD_CYCLES=4, REPEAT_CYCLES=2)
REQ-042 Load 58, then add pulsed for 1 cycle twice -> value 59, then 0; carry_pos high for exactly one cycle on the second step; tens/units 0/0.
REQ-043 add held 10 cycles from value 10 -> steps in cycle 0, cycle 4, then every 2 cycles -> value 14 on release.
REQ-044 Value 0, subtract pulsed, WRAP=1 -> value 59 with carry_neg pulse; same with WRAP=0 -> value 0 with no pulse.
REQ-045 add and subtract high together, then load 75 -> value unchanged during the overlap; after load, value 59.
REQ-046 rst asserted mid-REPEAT with add held -> value INIT and no carries; after rst drops, no step until add is released and pressed again.
REQ-047 en low with add toggling -> value frozen; load 30 with en low -> value 30.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock field counters: hold/repeat FSM
// state encoding and the standard field limits.
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } hr_state_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;

endpackage

// File: rtl/hold_repeat.sv
// Button edge detection plus hold/auto-repeat sequencing. Emits single-cycle
// step_up / step_dn strobes that the owner applies on the same clock edge.
module hold_repeat
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic load,
    input  logic add,
    input  logic subtract,
    output logic step_up,
    output logic step_dn
);

    localparam int MAXC  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    hr_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             dir, dir_d;      // 0 = add held, 1 = subtract held
    logic             prev_add, prev_sub;
    logic             lockout;         // set by reset until both buttons are released

    logic both, rise_up, rise_dn, held;

    assign both    = add & subtract;
    assign rise_up = add & ~prev_add & ~subtract;
    assign rise_dn = subtract & ~prev_sub & ~add;
    assign held    = dir ? subtract : add;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            dir      <= 1'b0;
            prev_add <= 1'b0;
            prev_sub <= 1'b0;
            lockout  <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            dir      <= dir_d;
            prev_add <= add;
            prev_sub <= subtract;
            if (!add && !subtract)
                lockout <= 1'b0;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dir_d   = dir;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (!en || load || both) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!lockout && (rise_up || rise_dn)) begin
                        step_up = rise_up;
                        step_dn = rise_dn;
                        dir_d   = rise_dn;
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD: begin
                    if (!held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        step_up = ~dir;
                        step_dn = dir;
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!held) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt == REP_LAST) begin
                        step_up = ~dir;
                        step_dn = dir;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/program_field_counter.sv
// Settable time-field counter (hours/minutes style): value register with
// wrap-or-saturate stepping, clamped load, carry pulses and a BCD split.
module program_field_counter
    import alarm_pkg::*;
#(
    parameter int MAX           = MIN_MAX,
    parameter int WIDTH         = 7,
    parameter int WRAP          = 1,
    parameter int HOLD_CYCLES   = 500,
    parameter int REPEAT_CYCLES = 100,
    parameter int INIT          = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] start_value,
    input  logic             add,
    input  logic             subtract,
    output logic [WIDTH-1:0] value,
    output logic [3:0]       tens,
    output logic [3:0]       units,
    output logic             carry_pos,
    output logic             carry_neg
);

    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic step_up, step_dn;

    hold_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_hold_repeat (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .add      (add),
        .subtract (subtract),
        .step_up  (step_up),
        .step_dn  (step_dn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            value     <= INIT_V;
            carry_pos <= 1'b0;
            carry_neg <= 1'b0;
        end else begin
            carry_pos <= 1'b0;
            carry_neg <= 1'b0;
            if (load) begin
                value <= (start_value > MAX_V) ? MAX_V : start_value;
            end else if (step_up) begin
                if (value == MAX_V) begin
                    if (WRAP != 0) begin
                        value     <= '0;
                        carry_pos <= 1'b1;
                    end
                end else begin
                    value <= value + 1'b1;
                end
            end else if (step_dn) begin
                if (value == '0) begin
                    if (WRAP != 0) begin
                        value     <= MAX_V;
                        carry_neg <= 1'b1;
                    end
                end else begin
                    value <= value - 1'b1;
                end
            end
        end
    end

    // MAX <= 99 keeps both digits within a nibble
    assign tens  = 4'(32'(value) / 32'd10);
    assign units = 4'(32'(value) % 32'd10);

endmodule

// File: tb/tb_program_field_counter.sv
// Scoreboard bench: expected field state is queued as each cycle is driven
// and compared just after the clock edge that should produce it.
module tb_program_field_counter;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst, en, load, add, subtract;
    logic [W-1:0] start_value;
    logic [W-1:0] value, value_s;
    logic [3:0]   tens, units, tens_s, units_s;
    logic         carry_pos, carry_neg, carry_pos_s, carry_neg_s;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int val;
        int cp;
        int cn;
        bit sat_en;
        int sval;
        int scp;
        int scn;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    program_field_counter #(
        .MAX(59), .WIDTH(W), .WRAP(1), .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .INIT(0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .start_value(start_value),
        .add(add), .subtract(subtract), .value(value), .tens(tens), .units(units),
        .carry_pos(carry_pos), .carry_neg(carry_neg)
    );

    program_field_counter #(
        .MAX(59), .WIDTH(W), .WRAP(0), .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .INIT(0)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en), .load(load), .start_value(start_value),
        .add(add), .subtract(subtract), .value(value_s), .tens(tens_s), .units(units_s),
        .carry_pos(carry_pos_s), .carry_neg(carry_neg_s)
    );

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("value", int'(value), e.val);
            chk("tens", int'(tens), e.val / 10);
            chk("units", int'(units), e.val % 10);
            chk("carry_pos", int'(carry_pos), e.cp);
            chk("carry_neg", int'(carry_neg), e.cn);
            if (e.sat_en) begin
                chk("sat_value", int'(value_s), e.sval);
                chk("sat_carry_pos", int'(carry_pos_s), e.scp);
                chk("sat_carry_neg", int'(carry_neg_s), e.scn);
            end
        end
    end

    // Drive one cycle of stimulus and queue what the WRAP=1 instance must show.
    task automatic drv(input bit r, input bit e_n, input bit l, input int sv,
                       input bit a, input bit s, input int ev, input int ecp, input int ecn);
        exp_t x;
        rst = r; en = e_n; load = l; start_value = W'(sv); add = a; subtract = s;
        x = '{val: ev, cp: ecp, cn: ecn, sat_en: 1'b0, sval: 0, scp: 0, scn: 0};
        sbq.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Same, additionally checking the saturating instance.
    task automatic drv_s(input bit l, input int sv, input bit a, input bit s,
                         input int ev, input int ecp, input int ecn,
                         input int esv, input int escp, input int escn);
        exp_t x;
        rst = 1'b0; en = 1'b1; load = l; start_value = W'(sv); add = a; subtract = s;
        x = '{val: ev, cp: ecp, cn: ecn, sat_en: 1'b1, sval: esv, scp: escp, scn: escn};
        sbq.push_back(x);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int ev;
        rst = 1'b1; en = 1'b0; load = 1'b0; start_value = '0; add = 1'b0; subtract = 1'b0;
        #2;
        // reset
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 40, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // load 58, two single-cycle add presses: 59 then wrap to 0 with carry
        drv_s(1, 58, 0, 0, 58, 0, 0, 58, 0, 0);
        drv_s(0, 0, 0, 0, 58, 0, 0, 58, 0, 0);
        drv_s(0, 0, 1, 0, 59, 0, 0, 59, 0, 0);
        drv_s(0, 0, 0, 0, 59, 0, 0, 59, 0, 0);
        drv_s(0, 0, 1, 0, 0, 1, 0, 59, 0, 0);
        drv_s(0, 0, 0, 0, 0, 0, 0, 59, 0, 0);

        // add held 10 cycles from 10: steps on cycles 0, 4, 6, 8
        drv(0, 1, 1, 10, 0, 0, 10, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 10, 0, 0);
        ev = 10;
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || i == 4 || i == 6 || i == 8) ev++;
            drv(0, 1, 0, 0, 1, 0, ev, 0, 0);
        end
        drv(0, 1, 0, 0, 0, 0, 14, 0, 0);

        // decrement at 0: wrap with carry vs saturate
        drv_s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drv_s(0, 0, 0, 1, 59, 0, 1, 0, 0, 0);
        drv_s(0, 0, 0, 0, 59, 0, 0, 0, 0, 0);

        // both buttons high: no steps; load 75 clamps to 59
        drv(0, 1, 1, 20, 0, 0, 20, 0, 0);
        drv(0, 1, 0, 0, 1, 1, 20, 0, 0);
        for (int i = 0; i < 6; i++) drv(0, 1, 0, 0, 1, 1, 20, 0, 0);
        drv(0, 1, 1, 75, 1, 1, 59, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 59, 0, 0);

        // reset mid-REPEAT with add held; no step until a fresh press
        drv(0, 1, 1, 10, 0, 0, 10, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 10, 0, 0);
        ev = 10;
        for (int i = 0; i < 7; i++) begin
            if (i == 0 || i == 4 || i == 6) ev++;
            drv(0, 1, 0, 0, 1, 0, ev, 0, 0);
        end
        drv(1, 1, 0, 0, 1, 0, 0, 0, 0);
        drv(1, 1, 1, 33, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) drv(0, 1, 0, 0, 1, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 1, 0, 1, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 1, 0, 0);

        // en low: toggling add is ignored, load still works
        for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, i[0], 0, 1, 0, 0);
        drv(0, 0, 1, 30, 0, 0, 30, 0, 0);
        drv(0, 0, 0, 0, 1, 0, 30, 0, 0);
        drv(0, 1, 0, 0, 1, 0, 30, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 30, 0, 0);

        @(posedge clk);
        #2;
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
